box_muller_seq_ctrl: RTL

//  Sequencer for the Box-Muller Gaussian datapath: seeds the URNG, pulses the h1 (sqrt(-2ln)) and h2 (sin/cos) units,

---
 rtl/box_muller_pkg.sv | 30 +++
 rtl/box_muller_seq_ctrl_fifo.sv | 54 +++++
 rtl/box_muller_seq_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/box_muller_pkg.sv
// Shared constants for the Box-Muller sequencer: state codes, default seed,
// fixed-point widths and the Q5.26 -> Q4.11 saturating rescale.
package box_muller_pkg;

    localparam logic [31:0] DEF_SEED = 32'h5C27_66A3;

    localparam int H1_W   = 16;
    localparam int TRIG_W = 16;
    localparam int GRV_W  = 16;
    localparam int PROD_W = 32;

    localparam logic [GRV_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [GRV_W-1:0] SAT_MIN = 16'h8000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEED  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_MERGE = 3'd4;
    localparam logic [2:0] ST_CHECK = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // Bits [31:30] must both equal the sign for [30:15] to be a faithful Q4.11 value.
    function automatic logic [GRV_W-1:0] scale_sat(input logic [PROD_W-1:0] p);
        if (p[31] != p[30])
            return p[31] ? SAT_MIN : SAT_MAX;
        return p[30:15];
    endfunction

endpackage

// File: rtl/box_muller_seq_ctrl_fifo.sv
// Synchronous pair FIFO (bm_pair_fifo): power-of-two depth, registered count,
// pointers wrap naturally; pushes when full and pops when empty are dropped.
module bm_pair_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/box_muller_seq_ctrl.sv
// Box-Muller sequencer: seeds the URNG, launches the h1/h2 units one pair at a
// time, joins their done flags, forms grv1/grv2 and queues pairs for the consumer.
module box_muller_seq_ctrl
    import box_muller_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [31:0] DEF_SEED    = box_muller_pkg::DEF_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] sample_cnt,
    input  logic        stop,
    input  logic [31:0] seed_i,
    output logic        load_seed,
    output logic [31:0] seed_o,
    output logic        unit_en,
    input  logic        h1_done,
    input  logic [15:0] h1_data,
    input  logic        h2_done,
    input  logic [15:0] sin_data,
    input  logic [15:0] cos_data,
    output logic [15:0] grv1,
    output logic [15:0] grv2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        err_timeout
);
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYC - 1);

    logic [2:0]         state;
    logic [15:0]        sample_target;
    logic [15:0]        produced;
    logic [15:0]        wait_cnt;
    logic               h1_seen;
    logic               h2_seen;
    logic [H1_W-1:0]    h1_q;
    logic [TRIG_W-1:0]  sin_q;
    logic [TRIG_W-1:0]  cos_q;

    logic signed [PROD_W-1:0] h1_ext;
    logic signed [PROD_W-1:0] sin_ext;
    logic signed [PROD_W-1:0] cos_ext;
    logic signed [PROD_W-1:0] p1;
    logic signed [PROD_W-1:0] p2;

    logic [2*GRV_W-1:0]          fifo_wdata;
    logic [2*GRV_W-1:0]          fifo_rdata;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        both_in;

    assign load_seed = (state == ST_SEED);
    assign unit_en   = (state == ST_ISSUE) && !fifo_full;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign out_valid = (fifo_count != '0);
    assign both_in   = (h1_seen || h1_done) && (h2_seen || h2_done);

    // h1 is unsigned, so it is zero-extended before the signed multiply.
    assign h1_ext     = {16'b0, h1_q};
    assign sin_ext    = {{16{sin_q[15]}}, sin_q};
    assign cos_ext    = {{16{cos_q[15]}}, cos_q};
    assign p1         = h1_ext * sin_ext;
    assign p2         = h1_ext * cos_ext;
    assign fifo_wdata = {scale_sat(p1), scale_sat(p2)};

    assign grv1 = fifo_empty ? '0 : fifo_rdata[31:16];
    assign grv2 = fifo_empty ? '0 : fifo_rdata[15:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            seed_o        <= DEF_SEED;
            sample_target <= '0;
            produced      <= '0;
            wait_cnt      <= '0;
            h1_seen       <= 1'b0;
            h2_seen       <= 1'b0;
            h1_q          <= '0;
            sin_q         <= '0;
            cos_q         <= '0;
            err_timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        seed_o        <= (seed_i == '0) ? DEF_SEED : seed_i;
                        sample_target <= sample_cnt;
                        produced      <= '0;
                        err_timeout   <= 1'b0;
                        state         <= ST_SEED;
                    end
                end
                ST_SEED: state <= ST_ISSUE;
                ST_ISSUE: begin
                    if (!fifo_full) begin
                        wait_cnt <= '0;
                        h1_seen  <= 1'b0;
                        h2_seen  <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (h1_done) begin
                        h1_seen <= 1'b1;
                        h1_q    <= h1_data;
                    end
                    if (h2_done) begin
                        h2_seen <= 1'b1;
                        sin_q   <= sin_data;
                        cos_q   <= cos_data;
                    end
                    wait_cnt <= wait_cnt + 16'd1;
                    // A join completing on the last allowed cycle still wins over the timeout.
                    if (both_in) begin
                        state <= ST_MERGE;
                    end else if (wait_cnt > WAIT_LIMIT) begin
                        err_timeout <= 1'b1;
                        h1_seen     <= 1'b0;
                        h2_seen     <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_MERGE: begin
                    h1_seen <= 1'b0;
                    h2_seen <= 1'b0;
                    state   <= ST_CHECK;
                end
                ST_CHECK: begin
                    produced <= produced + 16'd1;
                    if ((sample_target != '0 && produced + 16'd1 == sample_target) || stop)
                        state <= ST_DONE;
                    else
                        state <= ST_ISSUE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    bm_pair_fifo #(
        .WIDTH (2*GRV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (state == ST_MERGE),
        .wdata (fifo_wdata),
        .pop   (out_valid && out_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
